gemm_sched: RTL
===============

# gemm_sched

Job scheduler and sequencer for the shared DIM×DIM tau_mac GEMM array. Up to NUM_REQ requesters post GEMM jobs over valid/ready. The scheduler arbitrates among them and steers the winner's operands into the array. It then steps the array through DIM k-steps of WIDTH bit-cycles each and holds a result-valid handshake until the consumer takes the output matrix. The array contains only the MACs; this block owns all sequencing of it.

## Interface
- NUM_REQ, default 4: number of requesters. Must be ≥2.
- DIM, default 16: array dimension; number of k-steps per job.
- WIDTH, default 8: operand bitwidth; number of bit-cycles per k-step.
- DRAIN, default 1: wait cycles after the last bit-cycle before the result is valid. Legal range is 0..7.
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester job request. Once asserted, it is held until its req_ready.
- req_ready  out  NUM_REQ  one-hot grant. A handshake completes on any cycle where valid and ready are both high.
- op_sel  out  $clog2(NUM_REQ)  operand mux select for the granted requester.
- arr_clear  out  1  one-cycle accumulator clear to the array.
- arr_start  out  1  one-cycle start pulse at the beginning of each k-step.
- arr_k_idx  out  $clog2(DIM)  operand row/column index for the current k-step.
- res_valid  out  1  output matrix of the array is final.
- res_id  out  $clog2(NUM_REQ)  requester that owns the result.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, STEP, DRAIN_W, DONE.
- IDLE:
  - If any req_valid is high, the arbiter picks g and drives req_ready[g]=1 combinationally in the same cycle.
  - op_sel<=g; next state CLEAR.
  - If no request is pending, stay in IDLE with all strobes 0.
- CLEAR: arr_clear=1 for this cycle only; k<=0, bit counter<=0; next state STEP.
- STEP:
  - arr_start=1 when the bit counter is 0.
  - arr_k_idx=k throughout the step.
  - The bit counter counts 0..WIDTH-1.
  - At WIDTH-1: if k==DIM-1, go to DRAIN_W (or to DONE if DRAIN==0). Otherwise k<=k+1 and the bit counter goes to 0.
- DRAIN_W: count DRAIN cycles, then go to DONE.
- DONE: res_valid=1 and res_id=op_sel. Hold until res_ready, then go to IDLE.
- Arbitration (default): round-robin.
  - The pointer is 0 after reset.
  - The search starts at the pointer. After granting g, pointer<=(g+1) mod NUM_REQ.
  - The pointer updates only on a completed handshake.
- req_ready is 0 in every state other than IDLE. Requests arriving mid-job wait.
- op_sel is stable from the grant until DONE exits. arr_k_idx returns to 0 in IDLE.
- Counter widths: k uses $clog2(DIM) bits; the bit counter uses $clog2(WIDTH)+1 bits. Neither wraps; both are reset by CLEAR.

## Timing
- Reset values: req_ready=0, op_sel=0, arr_clear=0, arr_start=0, arr_k_idx=0, res_valid=0, res_id=0, busy=0; state IDLE, RR pointer 0.
- For a handshake in cycle T:
  - arr_clear at T+1.
  - First arr_start at T+2.
  - arr_start pulses at T+2+k·WIDTH for k=0..DIM-1.
  - res_valid first at T+2+DIM·WIDTH+DRAIN. With defaults this is T+131.
- busy rises at T+1 and falls in the cycle after the res_valid/res_ready handshake.
- The earliest next grant is the cycle after the result handshake. No back-to-back overlap.
- res_ready held high before DONE has no effect. In DONE, res_ready=1 on entry exits after exactly one res_valid cycle.
- Simultaneous requests in IDLE: exactly one grant. Non-granted requests keep waiting with req_ready=0.
- Reset asserted mid-job: all outputs return to reset values asynchronously. The in-flight job is dropped with no res_valid, and the requester must re-request.

## Configuration
- GEMM_SCHED_PRIO_EN defined: requester 0 has strict priority whenever its req_valid is high. Requesters 1..NUM_REQ-1 share round-robin among themselves, and a grant to 0 does not move the pointer.
- GEMM_SCHED_PRIO_EN undefined: pure round-robin over all NUM_REQ requesters as described in Operation.

## Test plan
- Single job, req_valid[2]=1 at T=5, defaults:
  - req_ready[2] at 5, arr_clear at 6.
  - arr_start at 7, 15, …, 127; arr_k_idx increments at each of these.
  - res_valid with res_id=2 at 136.
- All four requesters valid continuously, res_ready=1: grants go 0,1,2,3,0. busy drops for exactly one IDLE cycle between jobs.
- res_ready held 0 for 20 cycles in DONE: res_valid stays high with res_id stable, and no new req_ready appears. Releasing res_ready gives exit the next cycle.
- DRAIN=0, DIM=2, WIDTH=4: res_valid at T+10; DRAIN=3 gives T+13.
- reset_n pulsed low at T+50 mid-job: all outputs 0 immediately and no res_valid. The pending requester is re-granted once reset_n=1.
- With GEMM_SCHED_PRIO_EN and reqs 0 and 3 always valid: grants go 0,0,0. Drop req 0 and req 3 is granted next; after that the pointer is at 1.

Source files
------------

// File: rtl/gemm_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gemm_sched_if                                             |
// | Purpose  : Job request, array sequencing and result handshake bundle |
// |            between gemm_sched and its requesters/array/consumer.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface gemm_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DIM     = 16
) ();
  localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_k_w  = (DIM > 1) ? $clog2(DIM) : 1;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [c_id_w-1:0]  op_sel;
  logic               arr_clear;
  logic               arr_start;
  logic [c_k_w-1:0]   arr_k_idx;
  logic               res_valid;
  logic [c_id_w-1:0]  res_id;
  logic               res_ready;
  logic               busy;

  modport master (
    input  req_valid, res_ready,
    output req_ready, op_sel, arr_clear, arr_start, arr_k_idx,
           res_valid, res_id, busy
  );

  modport slave (
    output req_valid, res_ready,
    input  req_ready, op_sel, arr_clear, arr_start, arr_k_idx,
           res_valid, res_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/gemm_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : gemm_sched                                                |
// | Purpose  : Arbitrates GEMM jobs and sequences the DIMxDIM MAC array  |
// |            (clear, DIM k-steps of WIDTH bit-cycles, drain, result).  |
// |            Define GEMM_SCHED_PRIO_EN for strict priority on req 0.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module gemm_sched #(
  parameter int NUM_REQ = 4,
  parameter int DIM     = 16,
  parameter int WIDTH   = 8,
  parameter int DRAIN   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  gemm_sched_if.master bus
);
  localparam int c_id_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_k_w   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int c_bit_w = $clog2(WIDTH) + 1;

  localparam logic [c_id_w-1:0]  c_id_last   = c_id_w'(NUM_REQ - 1);
  localparam logic [c_id_w:0]    c_num_req   = (c_id_w + 1)'(NUM_REQ);
  localparam logic [c_k_w-1:0]   c_k_last    = c_k_w'(DIM - 1);
  localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(WIDTH - 1);
  localparam logic [2:0]         c_drain_last = 3'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_STEP    = 3'd2,
    S_DRAIN_W = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_id_w-1:0]  r_ptr;
  logic [c_id_w-1:0]  r_op_sel;
  logic [c_k_w-1:0]   r_k;
  logic [c_bit_w-1:0] r_bit;
  logic [2:0]         r_drain;
  logic               r_arr_clear;
  logic               r_arr_start;
  logic               r_res_valid;
  logic [c_id_w-1:0]  r_res_id;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;
  logic [c_id_w-1:0]  w_off;
  logic [c_id_w:0]    w_sum;
  logic [c_id_w-1:0]  w_grant;
  logic [c_id_w-1:0]  w_ptr_next;
  logic               w_any;

  // Rotate the candidates so bit 0 is the requester at the pointer; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    w_cand = bus.req_valid;
`ifdef GEMM_SCHED_PRIO_EN
    w_cand[0] = 1'b0;
`endif
    w_any = |bus.req_valid;
    w_rot = NUM_REQ'({w_cand, w_cand} >> r_ptr);
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = c_id_w'(i);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= c_num_req) begin
      w_sum = w_sum - c_num_req;
    end
    w_grant = w_sum[c_id_w-1:0];
`ifdef GEMM_SCHED_PRIO_EN
    // Requester 0 wins outright and leaves the 1..NUM_REQ-1 rotation alone.
    if (bus.req_valid[0]) begin
      w_grant    = '0;
      w_ptr_next = r_ptr;
    end else if (w_grant == c_id_last) begin
      w_ptr_next = c_id_w'(1);
    end else begin
      w_ptr_next = w_grant + 1'b1;
    end
`else
    w_ptr_next = (w_grant == c_id_last) ? '0 : w_grant + 1'b1;
`endif
  end

  // Grant is combinational, so it must also be forced low while in reset.
  assign bus.req_ready = (reset_n && r_state == S_IDLE && w_any)
                         ? (NUM_REQ'(1) << w_grant) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_op_sel    <= '0;
      r_k         <= '0;
      r_bit       <= '0;
      r_drain     <= '0;
      r_arr_clear <= 1'b0;
      r_arr_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_arr_clear <= 1'b0;
      r_arr_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op_sel    <= w_grant;
            r_ptr       <= w_ptr_next;
            r_arr_clear <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_k         <= '0;
          r_bit       <= '0;
          r_arr_start <= 1'b1;
          r_state     <= S_STEP;
        end
        S_STEP: begin
          if (r_bit == c_bit_last) begin
            if (r_k == c_k_last) begin
              r_drain <= '0;
              if (DRAIN == 0) begin
                r_res_valid <= 1'b1;
                r_res_id    <= r_op_sel;
                r_state     <= S_DONE;
              end else begin
                r_state <= S_DRAIN_W;
              end
            end else begin
              r_k         <= r_k + 1'b1;
              r_bit       <= '0;
              r_arr_start <= 1'b1;
            end
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        S_DRAIN_W: begin
          if (r_drain == c_drain_last) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_op_sel;
            r_state     <= S_DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_busy      <= 1'b0;
            r_k         <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_sel    = r_op_sel;
  assign bus.arr_clear = r_arr_clear;
  assign bus.arr_start = r_arr_start;
  assign bus.arr_k_idx = r_k;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.busy      = r_busy;
endmodule
`default_nettype wire
